data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Clocked, parametrised big-endian byte-addressable data memory for the MEM stage.
//  Supports byte, halfword and word access with optional sign extension.
//  Adds a Req/Ready/Valid handshake, a configurable read latency and misalignment faults.
//  Sits between the MEM-stage control and the memory array, feeding the writeback mux.
// PARAMETERS
//  ADDR_W      9   byte-address width; DEPTH = 2**ADDR_W bytes
//  READ_LAT    1   cycles from the accepting edge to read Valid; legal range 1..4
//  ALIGN_CHECK 1   1: misaligned half/word raises Fault; 0: no check, addresses wrap modulo DEPTH
// PORTS
//  Clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous, active-low reset
//  Req        in   1        access request; held with its fields until accepted
//  ReadWrite  in   1        1 = write, 0 = read
//  SE         in   1        sign-extend on byte/half reads
//  Size       in   2        00 byte, 01 half, 10 word, 11 word
//  Address    in   ADDR_W   byte address of the most-significant byte
//  DataIn     in   32       write data; byte/half use the low bits
//  Ready      out  1        block can accept Req this cycle
//  Valid      out  1        one-cycle response pulse (read data or write ack)
//  DataOut    out  32       read data; held until the next response
//  Fault      out  1        qualifies Valid; set on a misaligned access
// BEHAVIOUR
//  Reset (asynchronous, Reset_n = 0):
//   - Ready = 1, Valid = 0, Fault = 0, DataOut = 0; FSM returns to IDLE; latency counter cleared.
//   - Memory array contents are not reset.
//  FSM states: IDLE, WAIT, RESP.
//   - Ready = 1 only in IDLE.
//   - Acceptance occurs on the rising edge where Req & Ready = 1.
//   - IDLE -> RESP if READ_LAT = 1, or on any write or fault; otherwise IDLE -> WAIT.
//   - WAIT counts READ_LAT-1 cycles, then -> RESP.
//   - RESP lasts exactly 1 cycle with Valid = 1, then -> IDLE.
//   - Req while not Ready is ignored; the requester holds it.
//   - Result: a read gives Valid READ_LAT cycles after acceptance; one operation per READ_LAT+1 cycles.
//  Layout: big-endian; byte Address holds bits [31:24] of a word, [15:8] of a half.
//  Writes commit on the accepting edge.
//   - Size 00 writes DataIn[7:0].
//   - Size 01 writes DataIn[15:0].
//   - Size 1x writes DataIn[31:0].
//   - Response: Valid with Fault = 0; DataOut unchanged.
//  Reads snapshot the array on the accepting edge; a later write cannot alter an issued read.
//   - Size 00: {24 fill, b0}.
//   - Size 01: {16 fill, b0, b1}.
//   - Size 1x: {b0, b1, b2, b3}.
//   - fill = b0[7] when SE = 1, else 0; SE is ignored for words.
//  Misalignment, ALIGN_CHECK = 1 only:
//   - Half with Address[0] = 1, or word with Address[1:0] != 0.
//   - No array write; response after 1 cycle with Valid = 1, Fault = 1, DataOut = 0.
//  ALIGN_CHECK = 0: byte offsets Address+k wrap modulo DEPTH.
//  Reset mid-operation:
//   - A pending read is dropped with no Valid.
//   - A write already committed on its accepting edge stays in memory.
//  Fault is meaningful only while Valid = 1 and is 0 otherwise.
// TESTING
//  1. Write word 0xDEADBEEF @0x010, then read byte @0x010 with SE = 1 -> DataOut = 0xFFFFFFDE, Fault = 0.
//  2. Same data, read half @0x012 with SE = 0 -> 0x0000BEEF; read byte @0x013 with SE = 1 -> 0xFFFFFFEF.
//  3. Word write @0x011 with ALIGN_CHECK = 1 -> Valid & Fault after 1 cycle; word read @0x010 still 0xDEADBEEF.
//  4. READ_LAT = 3, read accepted at edge E -> Valid high only in the cycle after E+2;
//     Ready low until the edge ending Valid; a Req held throughout is accepted next.
//  5. ALIGN_CHECK = 0, ADDR_W = 9, write word 0x11223344 @0x1FE
//     -> bytes 0x1FE = 0x11, 0x1FF = 0x22, 0x000 = 0x33, 0x001 = 0x44.
//  6. READ_LAT = 4, Reset_n pulsed low 2 cycles after a read is accepted
//     -> no Valid; Ready = 1 and DataOut = 0 immediately on reset.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between MEM-stage control and the data memory
interface data_memory_ctrl_if #(parameter int ADDR_W = 9);
  logic              req;
  logic              read_write;
  logic              se;
  logic [1:0]        size;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              ready;
  logic              valid;
  logic [31:0]       data_out;
  logic              fault;
  modport master (output req, read_write, se, size, address, data_in,
                  input ready, valid, data_out, fault);
  modport slave  (input req, read_write, se, size, address, data_in,
                  output ready, valid, data_out, fault);
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: big-endian byte-addressable data memory with handshake, read latency and misalignment faults
module data_memory_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int READ_LAT    = 1,
  parameter int ALIGN_CHECK = 1
) (
  input logic             clk,
  input logic             reset_n,
  data_memory_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic              fill, misal, accept;
  logic [31:0]       rdata, rd_q;
  logic [1:0]        cnt;
  always_comb begin
    a0     = bus.address;
    a1     = a0 + ADDR_W'(1);
    a2     = a0 + ADDR_W'(2);
    a3     = a0 + ADDR_W'(3);
    b0     = mem[a0];
    b1     = mem[a1];
    b2     = mem[a2];
    b3     = mem[a3];
    fill   = bus.se & b0[7];
    rdata  = bus.size[1] ? {b0, b1, b2, b3} :
             bus.size[0] ? {{16{fill}}, b0, b1} : {{24{fill}}, b0};
    misal  = (ALIGN_CHECK != 0) &&
             (bus.size == 2'b01 ? bus.address[0] : (bus.size[1] && bus.address[1:0] != 2'b00));
    accept = bus.ready & bus.req;
  end
  // array has no reset; writes commit on the accepting edge
  always_ff @(posedge clk) begin
    if (accept && bus.read_write && !misal) begin
      if (bus.size[1]) begin
        mem[a0] <= bus.data_in[31:24];
        mem[a1] <= bus.data_in[23:16];
        mem[a2] <= bus.data_in[15:8];
        mem[a3] <= bus.data_in[7:0];
      end else if (bus.size[0]) begin
        mem[a0] <= bus.data_in[15:8];
        mem[a1] <= bus.data_in[7:0];
      end else begin
        mem[a0] <= bus.data_in[7:0];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.ready    <= 1'b1;
      bus.valid    <= 1'b0;
      bus.fault    <= 1'b0;
      bus.data_out <= '0;
      cnt          <= '0;
      rd_q         <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bus.ready <= 1'b0;
          if (bus.read_write || misal || READ_LAT == 1) begin
            state     <= RESP;
            bus.valid <= 1'b1;
            bus.fault <= misal;
            if (misal) bus.data_out <= '0;
            else if (!bus.read_write) bus.data_out <= rdata;
          end else begin
            state <= WAIT;
            cnt   <= 2'(READ_LAT - 2);
            rd_q  <= rdata;
          end
        end
        WAIT: if (cnt == 2'd0) begin
          state        <= RESP;
          bus.valid    <= 1'b1;
          bus.data_out <= rd_q;
        end else begin
          cnt <= cnt - 2'd1;
        end
        RESP: begin
          state     <= IDLE;
          bus.valid <= 1'b0;
          bus.fault <= 1'b0;
          bus.ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed bench over three configurations with a per-cycle reference model
module tb_data_memory_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, go = 1'b0;
  always #5 clk = ~clk;
  logic        req = 1'b0, rw = 1'b0, se = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [8:0]  addr = '0;
  logic [31:0] din = '0;
  int          sel = 0;
  int          tests = 0, fails = 0;
  data_memory_ctrl_if #(.ADDR_W(9)) b0 (), b1 (), b2 ();
  assign b0.req = req && sel == 0;
  assign b1.req = req && sel == 1;
  assign b2.req = req && sel == 2;
  assign {b0.read_write, b0.se, b0.size, b0.address, b0.data_in} = {rw, se, size, addr, din};
  assign {b1.read_write, b1.se, b1.size, b1.address, b1.data_in} = {rw, se, size, addr, din};
  assign {b2.read_write, b2.se, b2.size, b2.address, b2.data_in} = {rw, se, size, addr, din};
  data_memory_ctrl #(.ADDR_W(9), .READ_LAT(1), .ALIGN_CHECK(1)) d0 (.clk(clk), .reset_n(rst_n), .bus(b0.slave));
  data_memory_ctrl #(.ADDR_W(9), .READ_LAT(3), .ALIGN_CHECK(1)) d1 (.clk(clk), .reset_n(rst_n), .bus(b1.slave));
  data_memory_ctrl #(.ADDR_W(9), .READ_LAT(4), .ALIGN_CHECK(0)) d2 (.clk(clk), .reset_n(rst_n), .bus(b2.slave));
  logic        ready_m, valid_m, fault_m;
  logic [31:0] dout_m;
  assign ready_m = sel == 0 ? b0.ready    : sel == 1 ? b1.ready    : b2.ready;
  assign valid_m = sel == 0 ? b0.valid    : sel == 1 ? b1.valid    : b2.valid;
  assign fault_m = sel == 0 ? b0.fault    : sel == 1 ? b1.fault    : b2.fault;
  assign dout_m  = sel == 0 ? b0.data_out : sel == 1 ? b1.data_out : b2.data_out;
  // reference model: byte arrays per instance and a countdown to the response cycle
  logic [7:0]  mm [3][512];
  int          cnt_e = 0;
  logic        pw = 1'b0, pf = 1'b0;
  logic [31:0] pd = '0, dout_e = '0;
  function automatic int lat_of(int s);
    return s == 0 ? 1 : s == 1 ? 3 : 4;
  endfunction
  function automatic int nb_of(logic [1:0] sz);
    return sz[1] ? 4 : sz[0] ? 2 : 1;
  endfunction
  function automatic bit mis(int s, logic [1:0] sz, logic [8:0] a);
    return s < 2 && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
  endfunction
  function automatic logic [31:0] mread(int s, logic [1:0] sz, logic [8:0] a, logic sx);
    logic [31:0] v = '0;
    int n = nb_of(sz);
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(mm[s][9'(a + k)]);
    if (sx && n < 4 && mm[s][a][7]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_e  <= 0;
      dout_e <= '0;
      pf     <= 1'b0;
    end else if (cnt_e > 0) begin
      cnt_e <= cnt_e - 1;
      if (cnt_e == 2 && !pw) dout_e <= pd;
    end else if (req) begin
      pf    <= mis(sel, size, addr);
      pw    <= rw && !mis(sel, size, addr);
      pd    <= mis(sel, size, addr) ? 32'd0 : mread(sel, size, addr, se);
      cnt_e <= (rw || mis(sel, size, addr)) ? 1 : lat_of(sel);
      if (mis(sel, size, addr)) dout_e <= '0;
      else if (!rw && lat_of(sel) == 1) dout_e <= mread(sel, size, addr, se);
      if (rw && !mis(sel, size, addr))
        for (int k = 0; k < 4; k++)
          if (k < nb_of(size)) mm[sel][9'(addr + k)] <= 8'(din >> (8 * (nb_of(size) - 1 - k)));
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (go) begin
    chk("ready", 32'(ready_m), 32'(cnt_e == 0));
    chk("valid", 32'(valid_m), 32'(cnt_e == 1));
    chk("fault", 32'(fault_m), 32'(cnt_e == 1 && pf));
    chk("data_out", dout_m, dout_e);
  end
  task automatic sel_inst(input int k);
    @(negedge clk);
    #1 rst_n = 1'b0;
    req = 1'b0;
    sel = k;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic issue(input bit w, input bit s, input logic [1:0] sz, input logic [8:0] a,
                       input logic [31:0] d, input bit keep);
    rw = w; se = s; size = sz; addr = a; din = d; req = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (ready_m) break;
      if (n > 50) begin chk("accept_timeout", 32'(ready_m), 32'd1); break; end
    end
    @(posedge clk);
    #1 if (!keep) req = 1'b0;
  endtask
  task automatic wait_resp(output int lat, output logic [31:0] d, output logic f);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (valid_m) break;
      if (lat > 20) begin chk("valid_timeout", 32'(valid_m), 32'd1); break; end
    end
    d = dout_m;
    f = fault_m;
  endtask
  task automatic rd(input string n, input bit s, input logic [1:0] sz, input logic [8:0] a,
                    input logic [31:0] exp, input int exp_lat);
    int lat; logic [31:0] d; logic f;
    issue(1'b0, s, sz, a, '0, 1'b0);
    wait_resp(lat, d, f);
    chk(n, d, exp);
    chk({n, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({n, "_fault"}, 32'(f), 32'd0);
  endtask
  initial begin
    int lat; logic [31:0] d; logic f; int vcount;
    #2 rst_n = 1'b0;
    #1 go = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sel_inst(0);
    issue(1'b1, 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 1'b0);
    wait_resp(lat, d, f);
    chk("wr_lat", 32'(lat), 32'd1);
    chk("wr_fault", 32'(f), 32'd0);
    rd("rd_b010_se", 1'b1, 2'b00, 9'h010, 32'hFFFFFFDE, 1);
    rd("rd_h012", 1'b0, 2'b01, 9'h012, 32'h0000BEEF, 1);
    rd("rd_b013_se", 1'b1, 2'b00, 9'h013, 32'hFFFFFFEF, 1);
    rd("rd_h010_se", 1'b1, 2'b01, 9'h010, 32'hFFFFDEAD, 1);
    issue(1'b1, 1'b0, 2'b11, 9'h011, 32'h01020304, 1'b0);
    wait_resp(lat, d, f);
    chk("mis_wr_lat", 32'(lat), 32'd1);
    chk("mis_wr_fault", 32'(f), 32'd1);
    chk("mis_wr_data", d, 32'd0);
    rd("rd_w010", 1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 1);
    issue(1'b0, 1'b0, 2'b01, 9'h011, '0, 1'b0);
    wait_resp(lat, d, f);
    chk("mis_rd_fault", 32'(f), 32'd1);
    chk("mis_rd_data", d, 32'd0);
    sel_inst(1);
    issue(1'b1, 1'b0, 2'b10, 9'h020, 32'h80FF0102, 1'b0);
    wait_resp(lat, d, f);
    chk("lat3_wr_lat", 32'(lat), 32'd1);
    issue(1'b0, 1'b0, 2'b10, 9'h020, '0, 1'b1);
    wait_resp(lat, d, f);
    chk("lat3_rd_lat", 32'(lat), 32'd3);
    chk("lat3_rd_data", d, 32'h80FF0102);
    wait_resp(lat, d, f);
    req = 1'b0;
    chk("lat3_held_gap", 32'(lat), 32'd4);
    chk("lat3_held_data", d, 32'h80FF0102);
    rd("lat3_b021_se", 1'b1, 2'b00, 9'h021, 32'hFFFFFFFF, 3);
    sel_inst(2);
    issue(1'b1, 1'b0, 2'b10, 9'h1FE, 32'h11223344, 1'b0);
    wait_resp(lat, d, f);
    chk("wrap_wr_fault", 32'(f), 32'd0);
    rd("wrap_b1fe", 1'b0, 2'b00, 9'h1FE, 32'h00000011, 4);
    rd("wrap_b1ff", 1'b0, 2'b00, 9'h1FF, 32'h00000022, 4);
    rd("wrap_b000", 1'b0, 2'b00, 9'h000, 32'h00000033, 4);
    rd("wrap_b001", 1'b0, 2'b00, 9'h001, 32'h00000044, 4);
    rd("wrap_h1ff", 1'b0, 2'b01, 9'h1FF, 32'h00002233, 4);
    rd("wrap_w1fe", 1'b0, 2'b10, 9'h1FE, 32'h11223344, 4);
    issue(1'b0, 1'b0, 2'b10, 9'h000, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_m), 32'd1);
    chk("rst_dout", dout_m, 32'd0);
    chk("rst_valid", 32'(valid_m), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (8) begin @(negedge clk); if (valid_m) vcount++; end
    chk("rst_no_valid", 32'(vcount), 32'd0);
    issue(1'b1, 1'b0, 2'b00, 9'h005, 32'h00000077, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd("rst_kept_wr", 1'b0, 2'b00, 9'h005, 32'h00000077, 4);
    repeat (2) @(negedge clk);
    go = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
